// File: rtl/timer_pkg.sv
// Shared types and helpers for the millisecond timer bank.
package timer_pkg;

    // Channel FSM states: a channel is either parked or counting down.
    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_t;

    // Prescaler width: enough bits for 0..freq_khz-1, never narrower than 1 bit.
    function automatic int pre_width(input int freq_khz);
        int w;
        w = $clog2(freq_khz);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ms_timer_channel.sv
// One countdown channel: IDLE/RUN FSM plus count, reload and mode registers.
// Priority of simultaneous events is start > stop > tick.
module ms_timer_channel
    import timer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    input  logic [CNT_W-1:0] load,
    output logic             busy,
    output logic             expire,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    ch_state_t        state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [CNT_W-1:0] reload_reg, reload_next;
    logic             periodic_reg, periodic_next;
    logic             expire_reg, expire_next;

    // State and datapath registers; reset parks the channel with everything cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= CH_IDLE;
            count_reg    <= '0;
            reload_reg   <= '0;
            periodic_reg <= 1'b0;
            expire_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            reload_reg   <= reload_next;
            periodic_reg <= periodic_next;
            expire_reg   <= expire_next;
        end
    end

    // Next state and datapath: start wins over stop, stop wins over the ms tick.
    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        reload_next   = reload_reg;
        periodic_next = periodic_reg;
        expire_next   = 1'b0;
        if (start) begin
            if (load == '0) begin
                // A zero-length delay expires immediately and never enters RUN.
                state_next  = CH_IDLE;
                count_next  = '0;
                expire_next = 1'b1;
            end else begin
                // Restarting an active run silently abandons it (no expire).
                state_next    = CH_RUN;
                count_next    = load;
                reload_next   = load;
                periodic_next = periodic;
            end
        end else if (stop) begin
            // Count is kept so the caller can read how far the run got.
            if (state_reg == CH_RUN) begin
                state_next = CH_IDLE;
            end
        end else if (tick && state_reg == CH_RUN) begin
            if (count_reg > ONE) begin
                count_next = count_reg - ONE;
            end else begin
                expire_next = 1'b1;
                if (periodic_reg) begin
                    count_next = reload_reg;
                end else begin
                    count_next = '0;
                    state_next = CH_IDLE;
                end
            end
        end
    end

    // Outputs decode registered state only, so nothing is combinational from inputs.
    always_comb begin
        busy   = (state_reg == CH_RUN);
        expire = expire_reg;
        count  = count_reg;
    end

endmodule

// File: rtl/ms_timer_bank.sv
// Millisecond timer bank: shared prescaler feeding NUM_CH countdown channels.
module ms_timer_bank
    import timer_pkg::*;
#(
    parameter int FREQ_KHZ = 50000,
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tick_en,
    output logic                    msec_tick,
    input  logic [NUM_CH-1:0]       ch_start,
    input  logic [NUM_CH-1:0]       ch_stop,
    input  logic [NUM_CH-1:0]       ch_periodic,
    input  logic [NUM_CH*CNT_W-1:0] ch_load,
    output logic [NUM_CH-1:0]       ch_busy,
    output logic [NUM_CH-1:0]       ch_expire,
    output logic [NUM_CH*CNT_W-1:0] ch_count
);

    localparam int               PRE_W    = pre_width(FREQ_KHZ);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(FREQ_KHZ - 1);

    logic [PRE_W-1:0] pre_cnt_reg;
    logic             msec_tick_reg;

    // Free-running prescaler; full-equality wrap so non-power-of-two rates are exact.
    // Channel starts never touch it, so a channel's first ms is partial.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_reg   <= '0;
            msec_tick_reg <= 1'b0;
        end else if (tick_en) begin
            if (pre_cnt_reg == PRE_LAST) begin
                pre_cnt_reg   <= '0;
                msec_tick_reg <= 1'b1;
            end else begin
                pre_cnt_reg   <= pre_cnt_reg + PRE_W'(1);
                msec_tick_reg <= 1'b0;
            end
        end else begin
            msec_tick_reg <= 1'b0;
        end
    end

    assign msec_tick = msec_tick_reg;

    // One channel per bus slice; channel gi owns bits [gi*CNT_W +: CNT_W].
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        ms_timer_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .tick     (msec_tick_reg),
            .start    (ch_start[gi]),
            .stop     (ch_stop[gi]),
            .periodic (ch_periodic[gi]),
            .load     (ch_load[gi*CNT_W +: CNT_W]),
            .busy     (ch_busy[gi]),
            .expire   (ch_expire[gi]),
            .count    (ch_count[gi*CNT_W +: CNT_W])
        );
    end

endmodule
